// File: rtl/mem_uart_tx_dumper_if.sv
// Bus bundle for the memory-to-uart result dumper.
// master: the dumper (drives memory address/strobe, uart byte/valid, status).
// slave : the surroundings (control, memory read data, uart done).
interface mem_uart_tx_dumper_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_done;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, word_count, mem_rdata, tx_done,
    output mem_addr, mem_rd_en, tx_dv, tx_byte, busy, done
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, tx_done,
    input  mem_addr, mem_rd_en, tx_dv, tx_byte, busy, done
  );
endinterface

// File: rtl/mem_uart_tx_dumper.sv
// Streams word_count 32-bit words from a 1-cycle-latency memory to a uart_tx,
// LSB first, one byte per tx_done handshake plus GAP_CLKS idle clocks.
// Optional: define DUMP_NEWLINE_TERM_EN to append a single 8'h0A terminator.
module mem_uart_tx_dumper #(
  parameter int          MEM_SIZE = 512,
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] GAP_CLKS = 16'd100
) (
  input  logic                 clk_i,
  input  logic                 rst_i,   // synchronous, active low
  mem_uart_tx_dumper_if.master bus_io
);
  typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT_TX, GAP, FIN} state_t;

  localparam logic [ADDR_W-1:0] MEM_SZ    = ADDR_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, rem_q, mem_addr_q;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx_q;
  logic [15:0]       gap_q;
  logic              term_q;
  logic              mem_rd_en_q, tx_dv_q, busy_q, done_q;
  logic [7:0]        tx_byte_q;

  logic [ADDR_W-1:0] addr_d, cnt_d, base_d;
  logic              gap_end;

  // Next address (wrapping), clamped count, folded base, and end-of-gap strobe.
  // With GAP_CLKS==0 the gap is skipped: tx_done itself ends the byte.
  always_comb begin
    addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ONE;
    cnt_d   = (bus_io.word_count > MEM_SZ) ? MEM_SZ : bus_io.word_count;
    base_d  = bus_io.base_addr % MEM_SZ;
    gap_end = ((state_q == GAP) && (gap_q == 16'd1)) ||
              ((state_q == WAIT_TX) && bus_io.tx_done && (GAP_CLKS == 16'd0));
  end

  // Dump FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_addr_q  <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      gap_q       <= '0;
      term_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (gap_end) begin
      if (term_q) begin
        term_q  <= 1'b0;
        state_q <= FIN;
      end else if (byte_idx_q != 2'd3) begin
        word_q     <= word_q >> 8;
        byte_idx_q <= byte_idx_q + 2'd1;
        tx_byte_q  <= word_q[15:8];
        tx_dv_q    <= 1'b1;
        state_q    <= SEND;
      end else begin
        rem_q  <= rem_q - ONE;
        addr_q <= addr_d;
        if (rem_q > ONE) begin
          mem_addr_q  <= addr_d;
          mem_rd_en_q <= 1'b1;
          state_q     <= RD;
        end else begin
`ifdef DUMP_NEWLINE_TERM_EN
          term_q    <= 1'b1;
          tx_byte_q <= 8'h0A;
          tx_dv_q   <= 1'b1;
          state_q   <= SEND;
`else
          state_q   <= FIN;
`endif
        end
      end
    end else begin
      case (state_q)
        IDLE: if (bus_io.start) begin
          addr_q <= base_d;
          rem_q  <= cnt_d;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (cnt_d == '0) begin
`ifdef DUMP_NEWLINE_TERM_EN
            term_q    <= 1'b1;
            tx_byte_q <= 8'h0A;
            tx_dv_q   <= 1'b1;
            state_q   <= SEND;
`else
            state_q   <= FIN;
`endif
          end else begin
            mem_addr_q  <= base_d;
            mem_rd_en_q <= 1'b1;
            state_q     <= RD;
          end
        end
        RD: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= LATCH;
        end
        LATCH: begin
          word_q     <= bus_io.mem_rdata;
          byte_idx_q <= 2'd0;
          tx_byte_q  <= bus_io.mem_rdata[7:0];
          tx_dv_q    <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          tx_dv_q <= 1'b0;
          state_q <= WAIT_TX;
        end
        WAIT_TX: if (bus_io.tx_done) begin
          gap_q   <= GAP_CLKS;
          state_q <= GAP;
        end
        GAP: gap_q <= gap_q - 16'd1;
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_rd_en = mem_rd_en_q;
  assign bus_io.tx_dv     = tx_dv_q;
  assign bus_io.tx_byte   = tx_byte_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
endmodule

// File: tb/tb_mem_uart_tx_dumper.sv
// Scoreboard bench for mem_uart_tx_dumper: drivers push expected read addresses
// and bytes, a negedge monitor pops and compares on every mem_rd_en / tx_dv.
module tb_mem_uart_tx_dumper;
  localparam int          MEM_SIZE = 512;
  localparam int          ADDR_W   = 16;
  localparam logic [15:0] GAP      = 16'd4;
`ifdef DUMP_NEWLINE_TERM_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_uart_tx_dumper_if #(.ADDR_W(ADDR_W)) dif();
  mem_uart_tx_dumper #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .GAP_CLKS(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(dif)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0]       mem [MEM_SIZE];
  logic [7:0]        exp_byte_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int cyc = 0, dv_cnt = 0, rd_cnt = 0, first_dv_cyc = -1, first_rd_cyc = -1;
  int lat = 10;
  bit spur_en = 1'b0;
  logic tx_done_m = 1'b0;

  assign dif.tx_done = tx_done_m;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memory model
  always @(posedge clk) if (dif.mem_rd_en) dif.mem_rdata <= mem[dif.mem_addr[8:0]];

  // uart_tx model: tx_done pulse lat clocks after tx_dv, optional spurious repeat in GAP
  initial forever begin
    @(negedge clk);
    if (dif.tx_dv && rst) begin
      repeat (lat) @(negedge clk);
      tx_done_m = 1'b1;
      @(negedge clk);
      tx_done_m = 1'b0;
      if (spur_en) begin
        @(negedge clk);
        tx_done_m = 1'b1;
        @(negedge clk);
        tx_done_m = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // monitor: every strobe is compared against the scoreboard queues
  always @(negedge clk) if (rst) begin
    if (dif.mem_rd_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rd actual=%0h expected=none", dif.mem_addr);
      end else chk("mem_addr", 32'(dif.mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (dif.tx_dv) begin
      dv_cnt++;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      if (exp_byte_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_tx_dv actual=%0h expected=none", dif.tx_byte);
      end else chk("tx_byte", 32'(dif.tx_byte), 32'(exp_byte_q.pop_front()));
    end
  end

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    exp_addr_q.push_back(a);
    for (int b = 0; b < 4; b++) exp_byte_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_term();
    if (TERM != 0) exp_byte_q.push_back(8'h0A);
  endtask

  task automatic clr_stats();
    dv_cnt = 0; rd_cnt = 0; first_dv_cyc = -1; first_rd_cyc = -1;
  endtask

  // pulse start for one clock; s = cycle stamp of the negedge right after acceptance
  task automatic do_start(input logic [15:0] base, input logic [15:0] cnt, output int s);
    @(negedge clk);
    dif.base_addr = base; dif.word_count = cnt; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    s = cyc;
    chk("busy_after_start", 32'(dif.busy), 1);
    chk("done_cleared", 32'(dif.done), 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!(dif.done && !dif.busy) && n < budget) begin @(negedge clk); n++; end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s timeout busy=%0d done=%0d expected busy=0 done=1", nm, dif.busy, dif.done);
    end
    chk({nm, "_bytes_left"}, 32'(exp_byte_q.size()), 0);
    chk({nm, "_reads_left"}, 32'(exp_addr_q.size()), 0);
  endtask

  task automatic wait_dv(input int target, input int budget);
    int n = 0;
    while (dv_cnt < target && n < budget) begin @(negedge clk); n++; end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_tx_dv timeout actual=%0d expected=%0d", dv_cnt, target);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    dif.start = 1'b0; dif.base_addr = '0; dif.word_count = '0; dif.mem_rdata = '0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", 32'(dif.tx_dv), 0);
    chk("rst_rd_en", 32'(dif.mem_rd_en), 0);
    chk("rst_busy", 32'(dif.busy), 0);
    chk("rst_done", 32'(dif.done), 0);
    rst = 1'b1;
    @(negedge clk);

    // T1: single word, latency and byte order
    mem[0] = 32'h44434241;
    clr_stats();
    exp_addr_q.push_back(16'd0);
    exp_byte_q.push_back(8'h41); exp_byte_q.push_back(8'h42);
    exp_byte_q.push_back(8'h43); exp_byte_q.push_back(8'h44);
    push_term();
    do_start(16'd0, 16'd1, s);
    wait_done("t1", 2000);
    chk("t1_rd_lat", 32'(first_rd_cyc - s), 0);
    // tx_dv is visible two negedges later, i.e. the uart takes it on the third edge
    chk("t1_dv_lat", 32'(first_dv_cyc - s), 2);
    chk("t1_dv_cnt", 32'(dv_cnt), 32'(4 + TERM));

    // T2: address wrap 511 -> 0
    mem[511] = 32'h11223344; mem[0] = 32'hAABBCCDD;
    clr_stats();
    exp_addr_q.push_back(16'd511); exp_addr_q.push_back(16'd0);
    exp_byte_q.push_back(8'h44); exp_byte_q.push_back(8'h33);
    exp_byte_q.push_back(8'h22); exp_byte_q.push_back(8'h11);
    exp_byte_q.push_back(8'hDD); exp_byte_q.push_back(8'hCC);
    exp_byte_q.push_back(8'hBB); exp_byte_q.push_back(8'hAA);
    push_term();
    do_start(16'd511, 16'd2, s);
    wait_done("t2", 4000);
    chk("t2_dv_cnt", 32'(dv_cnt), 32'(8 + TERM));

    // T3: zero count
    clr_stats();
    push_term();
    do_start(16'd5, 16'd0, s);
    if (TERM == 0) begin
      @(negedge clk);
      chk("t3_done", 32'(dif.done), 1);
      chk("t3_busy", 32'(dif.busy), 0);
    end else wait_done("t3", 500);
    chk("t3_rd_cnt", 32'(rd_cnt), 0);
    chk("t3_dv_cnt", 32'(dv_cnt), 32'(TERM));

    // T4: start while busy ignored, spurious tx_done in GAP ignored
    mem[10] = 32'h03020100; mem[11] = 32'h07060504; mem[12] = 32'h0B0A0908;
    clr_stats();
    spur_en = 1'b1;
    push_word(16'd10, 32'h03020100);
    push_word(16'd11, 32'h07060504);
    push_word(16'd12, 32'h0B0A0908);
    push_term();
    do_start(16'd10, 16'd3, s);
    wait_dv(2, 500);
    @(negedge clk);
    dif.base_addr = 16'd0; dif.word_count = 16'd1; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    chk("t4_busy_kept", 32'(dif.busy), 1);
    wait_done("t4", 6000);
    chk("t4_dv_cnt", 32'(dv_cnt), 32'(12 + TERM));
    spur_en = 1'b0;

    // T5: reset while waiting for byte 2 to finish, then a clean dump
    mem[20] = 32'hDEADBEEF;
    clr_stats();
    exp_addr_q.push_back(16'd20);
    exp_byte_q.push_back(8'hEF); exp_byte_q.push_back(8'hBE);
    do_start(16'd20, 16'd1, s);
    wait_dv(2, 500);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_tx_dv", 32'(dif.tx_dv), 0);
    chk("t5_rd_en", 32'(dif.mem_rd_en), 0);
    chk("t5_busy", 32'(dif.busy), 0);
    chk("t5_done", 32'(dif.done), 0);
    chk("t5_tx_byte", 32'(dif.tx_byte), 0);
    chk("t5_mem_addr", 32'(dif.mem_addr), 0);
    repeat (20) @(negedge clk);
    chk("t5_quiet_dv", 32'(dv_cnt), 2);
    chk("t5_quiet_rd", 32'(rd_cnt), 1);
    mem[21] = 32'h55667788;
    clr_stats();
    exp_addr_q.push_back(16'd21);
    exp_byte_q.push_back(8'h88); exp_byte_q.push_back(8'h77);
    exp_byte_q.push_back(8'h66); exp_byte_q.push_back(8'h55);
    push_term();
    do_start(16'd21, 16'd1, s);
    wait_done("t5b", 2000);
    chk("t5b_dv_cnt", 32'(dv_cnt), 32'(4 + TERM));

    // T6: count 600 clamped to 512 words
    lat = 2;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = {16'(i) ^ 16'hA5A5, 16'(i)};
    clr_stats();
    for (int i = 0; i < MEM_SIZE; i++) push_word(ADDR_W'(i), mem[i]);
    push_term();
    do_start(16'd0, 16'd600, s);
    wait_done("t6", 40000);
    chk("t6_dv_cnt", 32'(dv_cnt), 32'(2048 + TERM));
    chk("t6_rd_cnt", 32'(rd_cnt), 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_uart_tx_dumper.md
Name: mem_uart_tx_dumper

Overview:
- Streams a block of 32-bit words from a synchronous-read word memory out through a byte-wide uart_tx-style interface.
- Sends 4 bytes per word, least significant byte first.
- Paces each byte on the transmitter's done handshake, not on a fixed timer, then waits a programmable inter-byte gap.
- Serves as the result-dump path of the string-search system, opposite the UART load path that fills instruction/data memory.

Parameters:
- MEM_SIZE, 512, memory depth in words; addresses wrap modulo MEM_SIZE.
- ADDR_W, 16, width of the address, base and count buses.
- GAP_CLKS, 16'd100, idle clocks after each tx_done before the next tx_dv; 0 allowed.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin dump; sampled only when busy==0.
- base_addr  input  ADDR_W  first word address, latched on accepted start.
- word_count  input  ADDR_W  number of words to send, latched on accepted start.
- mem_addr  output  ADDR_W  word address to memory.
- mem_rd_en  output  1  read strobe; rdata is valid the cycle after.
- mem_rdata  input  32  read data, 1-cycle latency.
- tx_dv  output  1  one-cycle byte-valid pulse to uart_tx.
- tx_byte  output  8  byte to send; held stable until tx_done.
- tx_done  input  1  one-cycle pulse from uart_tx at end of stop bit.
- busy  output  1  high from accepted start until done.
- done  output  1  level; set at completion, cleared by next accepted start (LED).

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0. FSM goes to IDLE. Internal counters clear. Applies mid-transfer: tx_dv is low the cycle after, with no further memory reads.
- States: IDLE, RD, LATCH, SEND, WAIT_TX, GAP, FIN.
- IDLE:
  - start==1 latches base_addr and word_count (clamped to MEM_SIZE if larger), sets busy=1, clears done.
  - If the clamped count is 0, go to FIN. Otherwise go to RD.
- RD: mem_addr=current address; mem_rd_en=1 for exactly this one cycle; go to LATCH.
- LATCH: capture mem_rdata into a 32-bit shift word; byte_idx=0; go to SEND.
- SEND: tx_byte=word[7:0]; tx_dv=1 for one cycle; go to WAIT_TX.
- WAIT_TX: tx_dv=0; stay until tx_done==1, then go to GAP.
- GAP:
  - Count GAP_CLKS cycles; skipped when GAP_CLKS==0.
  - When the gap ends with byte_idx<3: shift word right 8, byte_idx+1, go to SEND.
  - When byte_idx==3: decrement remaining, address = (address+1) mod MEM_SIZE, go to RD if remaining>0, else go to FIN.
- FIN: busy=0, done=1; go to IDLE the same cycle.
- Latency: start accepted at edge N gives mem_rd_en at N+1, data latch at N+2, first tx_dv at N+3.
- Handshake:
  - A tx_done outside WAIT_TX is ignored.
  - Exactly one tx_dv per byte.
  - A start while busy is ignored; the latched values are unaffected.
- Wrap: base_addr=MEM_SIZE-1, count 2 reads MEM_SIZE-1 then 0.
- Total bytes = 4 × clamped count (plus the terminator when enabled).

Optional Feature:
- Macro DUMP_NEWLINE_TERM_EN.
- Defined: after the last word's final GAP, the block emits one extra byte 8'h0A (SEND, WAIT_TX, GAP) before FIN. The zero-count case also emits only this 8'h0A. 0x0A matches the newline separator the load path uses.
- Undefined: no terminator; FIN follows the last data byte's gap directly.

Test Plan:
- mem[0]=32'h44434241, base 0, count 1, GAP_CLKS 4, tx_done 10 clks after each tx_dv -> tx_byte 41,42,43,44; exactly 4 tx_dv pulses; first tx_dv 3 clks after start; done=1, busy=0 at end.
- mem[511]=32'h11223344, mem[0]=32'hAABBCCDD, base 511, count 2 -> reads at addr 511 then 0; bytes 44,33,22,11,DD,CC,BB,AA.
- count 0 -> no mem_rd_en, no tx_dv; done=1 one clk after start (terminator build: a single 0A byte).
- start pulsed again during the 2nd byte of a 3-word dump; spurious tx_done injected in GAP -> ignored; still exactly 12 bytes, in order.
- rst=0 for one clk while in WAIT_TX of byte 2 -> next cycle all outputs 0, IDLE; a later start with count 1 dumps cleanly.
- count 600 with MEM_SIZE 512 -> 2048 bytes sent, then done.
